// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Optional saturation is enabled by defining BIN2BCD_SAT_EN.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } b2b_state_e;

    localparam bcd_digit_t  BCD_ADJ     = 4'd3;
    localparam bcd_digit_t  BCD_ADJ_THR = 4'd5;
    localparam logic [7:0]  BCD_SAT     = 8'h99;

endpackage

// File: rtl/bcd_dabble_digit.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_dabble_digit
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    assign digit_o = (digit_i >= BCD_ADJ_THR) ? digit_i + BCD_ADJ : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to two-digit packed BCD converter.
// Define BIN2BCD_SAT_EN to clamp overflowing results to 8'h99.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] bin_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       bcd_out,
    output logic             ovf
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    b2b_state_e       state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [11:0]      bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       bcd_out_q, bcd_out_d;
    logic             ovf_q, ovf_d;

    logic [11:0]      bcd_adj;
    logic [11:0]      bcd_shift;
    logic             hund_nz;
    logic [7:0]       result;

    for (genvar i = 0; i < 3; i++) begin : gen_digit
        bcd_dabble_digit u_digit (
            .digit_i (bcd_q[4*i +: 4]),
            .digit_o (bcd_adj[4*i +: 4])
        );
    end

    assign bcd_shift = {bcd_adj[10:0], bin_q[BIN_W-1]};
    assign hund_nz   = (bcd_shift[11:8] != 4'd0);

`ifdef BIN2BCD_SAT_EN
    assign result = hund_nz ? BCD_SAT : bcd_shift[7:0];
`else
    assign result = bcd_shift[7:0];
`endif

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        bcd_out_d   = bcd_out_q;
        ovf_d       = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d    = SHIFT;
                    bin_d      = bin_in;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                end
            end
            SHIFT: begin
                bcd_d = bcd_shift;
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 1'b1;
                // Outputs are loaded on the final shift so they are registered in DONE.
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    bcd_out_d   = result;
                    ovf_d       = hund_nz;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    cnt_d       = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            bcd_out_q   <= 8'h00;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            bcd_out_q   <= bcd_out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bcd_out   = bcd_out_q;
    assign ovf       = ovf_q;

    a_digit_le9 : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == SHIFT) |-> (bcd_shift[3:0] <= 4'd9 && bcd_shift[7:4] <= 4'd9
                                && bcd_shift[11:8] <= 4'd9));

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: cycle-level protocol model plus directed vectors.
module tb_bin2bcd_seq;

    localparam int BW = 8;
`ifdef BIN2BCD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] bin_in;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    bcd_out;
    logic          ovf;

    int n_pass  = 0;
    int n_total = 0;
    bit armed   = 1'b0;

    // Protocol model state
    bit         m_busy = 1'b0;
    int         m_wait = 0;
    logic [7:0] m_bcd  = 8'h00;
    logic       m_ovf  = 1'b0;

    bin2bcd_seq #(.BIN_W(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    function automatic int model_dec(input int v);
        if (v > 99) return SAT ? 99 : v % 100;
        return v;
    endfunction

    function automatic logic [7:0] model_bcd(input int v);
        int e;
        e = model_dec(v);
        return 8'((e / 10) * 16 + (e % 10));
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // Every-cycle compare against the model, sampled mid-cycle
    always @(negedge clk) begin
        if (armed) begin
            if (rst_n) begin
                check("in_ready", 32'(in_ready), 32'(!m_busy));
                check("out_valid", 32'(out_valid), 32'(m_busy && m_wait == 0));
                if (m_busy && m_wait == 0) begin
                    check("bcd_out", 32'(bcd_out), 32'(m_bcd));
                    check("ovf", 32'(ovf), 32'(m_ovf));
                end
                if (!m_busy) begin
                    if (in_valid) begin
                        m_busy = 1'b1;
                        m_wait = BW;
                        m_bcd  = model_bcd(int'(bin_in));
                        m_ovf  = (int'(bin_in) > 99);
                    end
                end else if (m_wait > 0) begin
                    m_wait--;
                end else if (out_ready) begin
                    m_busy = 1'b0;
                end
            end else begin
                m_busy = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("result_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run_conv(input int v, output logic [7:0] b, output logic o, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        in_valid  = 1'b1;
        bin_in    = v[BW-1:0];
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(lat);
        b = bcd_out;
        o = ovf;
        step();
    endtask

    initial begin
        logic [7:0] b;
        logic       o;
        int         lat;
        int         n;
        int         dec, prev_dec, prev_exp;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bin_in    = '0;
        step();
        step();
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_bcd_out", 32'(bcd_out), 32'h00);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        armed = 1'b1;

        // Zero input still takes the full shift sequence
        run_conv(0, b, o, lat);
        check("t1_latency", 32'(lat), 32'd8);
        check("t1_bcd", 32'(b), 32'h00);
        check("t1_ovf", 32'(o), 32'd0);

        // Back-to-back 99 then 47
        out_ready = 1'b1;
        in_valid  = 1'b1;
        bin_in    = 8'd99;
        step();
        bin_in = 8'd47;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready || n >= 50) break;
            if (out_valid) begin
                check("t2_bcd99", 32'(bcd_out), 32'h99);
                check("t2_ovf99", 32'(ovf), 32'd0);
            end
            n++;
            @(posedge clk);
            #1;
        end
        check("t2_busy_cycles", 32'(n), 32'd9);
        step();
        in_valid = 1'b0;
        wait_out(lat);
        check("t2_bcd47", 32'(bcd_out), 32'h47);
        check("t2_ovf47", 32'(ovf), 32'd0);
        step();

        // Overflowing operands
        run_conv(100, b, o, lat);
        check("t3_bcd100", 32'(b), SAT ? 32'h99 : 32'h00);
        check("t3_ovf100", 32'(o), 32'd1);
        run_conv(255, b, o, lat);
        check("t3_bcd255", 32'(b), SAT ? 32'h99 : 32'h55);
        check("t3_ovf255", 32'(o), 32'd1);

        // Backpressure in DONE; a new request must be ignored
        out_ready = 1'b0;
        in_valid  = 1'b1;
        bin_in    = 8'd200;
        step();
        in_valid = 1'b0;
        wait_out(lat);
        in_valid = 1'b1;
        bin_in   = 8'd5;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_bcd", 32'(bcd_out), SAT ? 32'h99 : 32'h00);
            check("t4_hold_ovf", 32'(ovf), 32'd1);
            check("t4_hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check("t4_release_valid", 32'(out_valid), 32'd0);
        check("t4_release_ready", 32'(in_ready), 32'd1);

        // Reset during the third shift cycle drops the conversion
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        bin_in   = 8'd63;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_ready", 32'(in_ready), 32'd1);
        check("t5_bcd", 32'(bcd_out), 32'h00);
        check("t5_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;
        run_conv(12, b, o, lat);
        check("t5_bcd12", 32'(b), 32'h12);

        // Full sweep with decimal decode and pairwise sums
        prev_dec = 0;
        prev_exp = 0;
        for (int v = 0; v < 256; v++) begin
            run_conv(v, b, o, lat);
            dec = int'(b[7:4]) * 10 + int'(b[3:0]);
            check("sweep_dec", 32'(dec), 32'(model_dec(v)));
            if (v % 2 == 1)
                check("sweep_pair_sum", 32'(prev_dec + dec), 32'(prev_exp + model_dec(v)));
            prev_dec = dec;
            prev_exp = model_dec(v);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
